// File: rtl/pdm_capture_sequencer.sv
// PDM microphone capture sequencer: warm-up discard, 16-bit packing, FWFT FIFO hand-off.
// Define PDM_DENSITY_EN to push the ones-count of each word instead of the raw bits.
module pdm_capture_sequencer #(
  parameter int FIFO_DEPTH    = 8,
  parameter int WARMUP_FRAMES = 4,
  parameter int NUM_FRAMES    = 0
) (
  input  logic        clk_2MHz,
  input  logic        btnRST,
  input  logic        start,
  input  logic        stop,
  input  logic        micDataPDM_wire,
  output logic        micEN,
  output logic [15:0] aud_data,
  output logic        aud_valid,
  input  logic        aud_ready,
  output logic        busy,
  output logic [1:0]  state_o,
  output logic        overflow,
  output logic [15:0] frame_cnt
);

  localparam int              AddrW     = $clog2(FIFO_DEPTH);
  localparam logic [AddrW:0]  FullCount = FIFO_DEPTH[AddrW:0];
  localparam logic [15:0]     WarmLast  = (WARMUP_FRAMES > 0) ? 16'(WARMUP_FRAMES - 1) : 16'd0;
  localparam logic [15:0]     FrameStop = 16'(NUM_FRAMES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } seqState_t;

  seqState_t      state;
  logic [3:0]     bitCnt;
  logic [15:0]    shiftReg;
  logic [15:0]    warmCnt;

  logic [15:0]    fifoMem [FIFO_DEPTH];
  logic [AddrW-1:0] wrPtr;
  logic [AddrW-1:0] rdPtr;
  logic [AddrW:0]   fifoCount;

  logic           packing;
  logic           wordDone;
  logic           fifoEmpty;
  logic           fifoFull;
  logic           doPop;
  logic           doPush;
  logic [15:0]    rawWord;
  logic [15:0]    pushWord;
  logic [15:0]    frameNext;

  assign packing   = (state == WARMUP) || (state == CAPTURE);
  assign rawWord   = {shiftReg[14:0], micDataPDM_wire};
  assign wordDone  = packing && (bitCnt == 4'd15);
  assign fifoEmpty = (fifoCount == '0);
  assign fifoFull  = (fifoCount == FullCount);
  assign doPop     = !fifoEmpty && aud_ready;
  // A full FIFO still accepts a word when the consumer frees a slot in the same cycle.
  assign doPush    = wordDone && (state == CAPTURE) && (!fifoFull || doPop);
  assign frameNext = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;

`ifdef PDM_DENSITY_EN
  // NOTE: always_comb variables get a default before the loop so no latch is inferred.
  always_comb begin
    pushWord = '0;
    for (int i = 0; i < 16; i++) begin
      pushWord = pushWord + {15'd0, rawWord[i]};
    end
  end
`else
  assign pushWord = rawWord;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_2MHz) begin
    if (!btnRST) begin
      state     <= IDLE;
      micEN     <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      warmCnt   <= '0;
    end else begin
      if (packing) begin
        shiftReg <= rawWord;
        bitCnt   <= bitCnt + 4'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            bitCnt    <= '0;
            shiftReg  <= '0;
            warmCnt   <= '0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
            micEN     <= 1'b1;
            busy      <= 1'b1;
            state     <= (WARMUP_FRAMES == 0) ? CAPTURE : WARMUP;
          end
        end
        WARMUP: begin
          if (wordDone) warmCnt <= warmCnt + 16'd1;
          if (stop) begin
            state <= DRAIN;
            micEN <= 1'b0;
          end else if (wordDone && (warmCnt == WarmLast)) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (wordDone) begin
            frame_cnt <= frameNext;
            if (!doPush) overflow <= 1'b1;
          end
          if (stop || (wordDone && (NUM_FRAMES != 0) && (frameNext == FrameStop))) begin
            state <= DRAIN;
            micEN <= 1'b0;
          end
        end
        DRAIN: begin
          if (fifoEmpty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_2MHz) begin
    if (!btnRST) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // NOTE: storage is not reset; the head is masked while empty so stale entries never reach aud_data.
  always_ff @(posedge clk_2MHz) begin
    if (doPush) fifoMem[wrPtr] <= pushWord;
  end

  assign aud_valid = !fifoEmpty;
  assign aud_data  = fifoEmpty ? 16'd0 : fifoMem[rdPtr];
  assign state_o   = state;

endmodule

// File: tb/tb_pdm_capture_sequencer.sv
// Self-checking bench for pdm_capture_sequencer against a queue-based behavioural model.
module tb_pdm_capture_sequencer;

  localparam int Depth = 8;
  localparam int Warm  = 4;

  logic        clk_2MHz = 1'b0;
  logic        btnRST;
  logic        start, stop, micDataPDM_wire, aud_ready;
  logic        micEN, aud_valid, busy, overflow;
  logic [15:0] aud_data, frame_cnt;
  logic [1:0]  state_o;

  logic        a2Start, a2Stop, a2Bit, a2Ready;
  logic        a2Mic, a2Valid, a2Busy, a2Ovf;
  logic [15:0] a2Data, a2Frame;
  logic [1:0]  a2State;

  int total = 0;
  int bad   = 0;

  always #5 clk_2MHz = ~clk_2MHz;

  pdm_capture_sequencer #(.FIFO_DEPTH(Depth), .WARMUP_FRAMES(Warm), .NUM_FRAMES(0)) dut (
    .clk_2MHz(clk_2MHz), .btnRST(btnRST), .start(start), .stop(stop),
    .micDataPDM_wire(micDataPDM_wire), .micEN(micEN), .aud_data(aud_data),
    .aud_valid(aud_valid), .aud_ready(aud_ready), .busy(busy), .state_o(state_o),
    .overflow(overflow), .frame_cnt(frame_cnt)
  );

  pdm_capture_sequencer #(.FIFO_DEPTH(4), .WARMUP_FRAMES(0), .NUM_FRAMES(3)) dutAuto (
    .clk_2MHz(clk_2MHz), .btnRST(btnRST), .start(a2Start), .stop(a2Stop),
    .micDataPDM_wire(a2Bit), .micEN(a2Mic), .aud_data(a2Data),
    .aud_valid(a2Valid), .aud_ready(a2Ready), .busy(a2Busy), .state_o(a2State),
    .overflow(a2Ovf), .frame_cnt(a2Frame)
  );

  logic [21:0] dutVec;
  assign dutVec = {state_o, busy, micEN, aud_valid, overflow, frame_cnt};

  // Behavioural model: state number, bit position inside the current word, queue of raw words.
  int          mSt, mBitCnt, mWarm;
  logic [15:0] mCur, mFrame;
  logic        mOvf;
  logic [15:0] mQ[$];

  function automatic logic [15:0] expW(input logic [15:0] raw);
`ifdef PDM_DENSITY_EN
    return 16'($countones(raw));
`else
    return raw;
`endif
  endfunction

  function automatic logic [21:0] expVec();
    logic [1:0] s;
    s = 2'(mSt);
    return {s, (mSt != 0), (mSt == 1 || mSt == 2), (mQ.size() != 0), mOvf, mFrame};
  endfunction

  task automatic modelStep(input logic st, input logic sp, input logic rdy, input logic b,
                           input logic rstn);
    int          sizeBefore;
    logic        pop, full, done;
    logic [15:0] word;
    if (!rstn) begin
      mSt = 0; mBitCnt = 0; mWarm = 0; mCur = '0; mFrame = '0; mOvf = 1'b0;
      mQ.delete();
      return;
    end
    sizeBefore = mQ.size();
    pop  = rdy && (sizeBefore != 0);
    full = (sizeBefore == Depth);
    done = 1'b0;
    word = '0;
    if (mSt == 1 || mSt == 2) begin
      word    = (mCur << 1) | 16'(b);
      done    = (mBitCnt == 15);
      mCur    = word;
      mBitCnt = (mBitCnt + 1) % 16;
    end
    if (pop) void'(mQ.pop_front());
    case (mSt)
      0: if (st) begin
        mSt = (Warm == 0) ? 2 : 1;
        mFrame = '0; mOvf = 1'b0; mBitCnt = 0; mCur = '0; mWarm = 0;
      end
      1: begin
        if (done) mWarm++;
        if (sp) mSt = 3;
        else if (done && mWarm == Warm) mSt = 2;
      end
      2: begin
        if (done) begin
          if (mFrame != 16'hFFFF) mFrame = mFrame + 16'd1;
          if (!full || pop) mQ.push_back(word);
          else mOvf = 1'b1;
        end
        if (sp) mSt = 3;
      end
      default: if (sizeBefore == 0) mSt = 0;
    endcase
  endtask

  task automatic tick(input logic st, input logic sp, input logic rdy, input logic b);
    start = st; stop = sp; aud_ready = rdy; micDataPDM_wire = b;
    modelStep(st, sp, rdy, b, btnRST);
    @(posedge clk_2MHz); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic stopAndDrain();
    tick(1'b0, 1'b1, 1'b1, 1'($urandom));
    for (int i = 0; i < 40 && mSt != 0; i++) tick(1'b0, 1'b0, 1'b1, 1'($urandom));
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (dutVec !== 22'd0) begin bad++; $display("FAIL reset_status: got %h want 0", dutVec); end
    total++; if (aud_data !== 16'd0) begin bad++; $display("FAIL reset_data: got %h want 0", aud_data); end
    btnRST = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 84; i++) tick(1'b0, 1'b0, 1'b0, 1'($urandom));
    total++; if (dutVec !== expVec()) begin bad++; $display("FAIL pre_reset_capture: got %h want %h", dutVec, expVec()); end
    btnRST = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (dutVec !== 22'd0) begin bad++; $display("FAIL midrun_reset_status: got %h want 0", dutVec); end
    total++; if (aud_data !== 16'd0) begin bad++; $display("FAIL midrun_reset_data: got %h want 0", aud_data); end
    btnRST = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_warmup_pack();
    logic [15:0] pat;
    logic        sawValid;
    pat = 16'hA5C3;
    sawValid = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL start_to_warmup: got %0d want 1", state_o); end
    for (int i = 0; i < 64; i++) begin
      tick(1'b0, 1'b0, 1'b0, pat[15 - (i % 16)]);
      if (aud_valid) sawValid = 1'b1;
    end
    total++; if (sawValid !== 1'b0) begin bad++; $display("FAIL warmup_pushed: got %b want 0", sawValid); end
    total++; if (dutVec !== expVec()) begin bad++; $display("FAIL warmup_to_capture: got %h want %h", dutVec, expVec()); end
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b0, pat[15 - (i % 16)]);
    total++; if (aud_valid !== 1'b0) begin bad++; $display("FAIL valid_early: got %b want 0", aud_valid); end
    tick(1'b0, 1'b0, 1'b0, pat[0]);
    total++; if (aud_valid !== 1'b1) begin bad++; $display("FAIL first_word_valid: got %b want 1", aud_valid); end
    total++; if (aud_data !== expW(pat)) begin bad++; $display("FAIL first_word_data: got %h want %h", aud_data, expW(pat)); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL first_word_count: got %0d want 1", frame_cnt); end
    stopAndDrain();
    total++; if (dutVec !== expVec() || state_o !== 2'd0) begin bad++; $display("FAIL pack_drain_idle: got %h want %h", dutVec, expVec()); end
  endtask

  task automatic test_overflow();
    int popCnt;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < (Warm + 10) * 16; i++) tick(1'b0, 1'b0, 1'b0, 1'($urandom));
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_flag: got %b want 1", overflow); end
    total++; if (frame_cnt !== 16'd10) begin bad++; $display("FAIL overflow_count: got %0d want 10", frame_cnt); end
    total++; if (dutVec !== expVec()) begin bad++; $display("FAIL overflow_status: got %h want %h", dutVec, expVec()); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    popCnt = 0;
    for (int i = 0; i < 30 && mSt != 0; i++) begin
      if (aud_valid) begin
        popCnt++;
        total++;
        if (mQ.size() == 0 || aud_data !== expW(mQ[0])) begin
          bad++; $display("FAIL overflow_order: word %0d got %h", popCnt, aud_data);
        end
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0);
    end
    total++; if (popCnt !== 8) begin bad++; $display("FAIL overflow_held: got %0d want 8", popCnt); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL overflow_idle: got %0d want 0", state_o); end
  endtask

  task automatic test_full_collision();
    int popCnt;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < (Warm + 8) * 16 + 15; i++) tick(1'b0, 1'b0, 1'b0, 1'($urandom));
    total++; if (frame_cnt !== 16'd8 || overflow !== 1'b0) begin bad++; $display("FAIL collision_pre: cnt %0d ovf %b want 8/0", frame_cnt, overflow); end
    tick(1'b0, 1'b0, 1'b1, 1'($urandom));
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL collision_overflow: got %b want 0", overflow); end
    total++; if (frame_cnt !== 16'd9) begin bad++; $display("FAIL collision_count: got %0d want 9", frame_cnt); end
    total++; if (aud_data !== expW(mQ[0])) begin bad++; $display("FAIL collision_head: got %h want %h", aud_data, expW(mQ[0])); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    popCnt = 0;
    for (int i = 0; i < 30 && mSt != 0; i++) begin
      if (aud_valid) begin
        popCnt++;
        total++;
        if (mQ.size() == 0 || aud_data !== expW(mQ[0])) begin
          bad++; $display("FAIL collision_order: word %0d got %h", popCnt, aud_data);
        end
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0);
    end
    total++; if (popCnt !== 8) begin bad++; $display("FAIL collision_stays_full: got %0d want 8", popCnt); end
  endtask

  task automatic test_control();
    logic sawValid;
    sawValid = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 1'($urandom));
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL ctl_in_warmup: got %0d want 1", state_o); end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    if (aud_valid) sawValid = 1'b1;
    total++; if (state_o !== 2'd3 || micEN !== 1'b0) begin bad++; $display("FAIL ctl_warmup_stop: state %0d mic %b want 3/0", state_o, micEN); end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    if (aud_valid) sawValid = 1'b1;
    total++; if (state_o !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL ctl_drain_idle: state %0d busy %b want 0/0", state_o, busy); end
    total++; if (sawValid !== 1'b0) begin bad++; $display("FAIL ctl_warmup_no_push: got %b want 0", sawValid); end
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL ctl_start_wins: got %0d want 1", state_o); end
    for (int i = 0; i < (Warm + 1) * 16 + 5; i++) tick(1'b0, 1'b0, 1'b0, 1'($urandom));
    tick(1'b1, 1'b0, 1'b0, 1'($urandom));
    total++; if (state_o !== 2'd2 || frame_cnt !== 16'd1) begin bad++; $display("FAIL ctl_start_ignored: state %0d cnt %0d want 2/1", state_o, frame_cnt); end
    total++; if (dutVec !== expVec()) begin bad++; $display("FAIL ctl_status: got %h want %h", dutVec, expVec()); end
    stopAndDrain();
  endtask

  task automatic test_autostop();
    logic        bits [48];
    logic [15:0] words [3];
    logic [15:0] popped[$];
    logic        sawDrain;
    for (int k = 0; k < 3; k++) words[k] = '0;
    for (int i = 0; i < 48; i++) begin
      bits[i] = 1'($urandom);
      words[i / 16] = words[i / 16] * 16'd2 + 16'(bits[i]);
    end
    sawDrain = 1'b0;
    a2Ready = 1'b1; a2Start = 1'b1;
    @(posedge clk_2MHz); #1;
    a2Start = 1'b0;
    total++; if (a2State !== 2'd2 || a2Mic !== 1'b1) begin bad++; $display("FAIL auto_start: state %0d mic %b want 2/1", a2State, a2Mic); end
    for (int c = 0; c < 80; c++) begin
      a2Bit = (c < 48) ? bits[c] : 1'($urandom);
      if (a2Valid && a2Ready) popped.push_back(a2Data);
      @(posedge clk_2MHz); #1;
      if (c == 46) begin
        total++; if (a2Mic !== 1'b1) begin bad++; $display("FAIL auto_mic_early: got %b want 1", a2Mic); end
      end
      if (c == 47) begin
        total++; if (a2Mic !== 1'b0 || a2State !== 2'd3) begin bad++; $display("FAIL auto_stop_edge: mic %b state %0d want 0/3", a2Mic, a2State); end
      end
      if (a2State == 2'd3) sawDrain = 1'b1;
      if (a2State == 2'd0) break;
    end
    total++; if (popped.size() !== 3) begin bad++; $display("FAIL auto_pop_count: got %0d want 3", popped.size()); end
    for (int k = 0; k < 3 && k < popped.size(); k++) begin
      total++; if (popped[k] !== expW(words[k])) begin bad++; $display("FAIL auto_word%0d: got %h want %h", k, popped[k], expW(words[k])); end
    end
    total++; if (sawDrain !== 1'b1 || a2State !== 2'd0 || a2Busy !== 1'b0) begin bad++; $display("FAIL auto_end: drain %b state %0d busy %b want 1/0/0", sawDrain, a2State, a2Busy); end
    total++; if (a2Frame !== 16'd3 || a2Ovf !== 1'b0) begin bad++; $display("FAIL auto_count: cnt %0d ovf %b want 3/0", a2Frame, a2Ovf); end
  endtask

  task automatic test_random_traffic();
    logic st, sp, rdy;
    for (int c = 0; c < 1500; c++) begin
      st  = ($urandom_range(0, 39) == 0);
      sp  = ($urandom_range(0, 249) == 0);
      rdy = (c < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick(st, sp, rdy, 1'($urandom));
      total++; if (dutVec !== expVec()) begin bad++; $display("FAIL rand_status @%0d: got %h want %h", c, dutVec, expVec()); end
      if (mQ.size() != 0) begin
        total++; if (aud_data !== expW(mQ[0])) begin bad++; $display("FAIL rand_data @%0d: got %h want %h", c, aud_data, expW(mQ[0])); end
      end
    end
    stopAndDrain();
    total++; if (dutVec !== expVec()) begin bad++; $display("FAIL rand_final: got %h want %h", dutVec, expVec()); end
  endtask

  initial begin
    btnRST = 1'b0;
    start = 1'b0; stop = 1'b0; micDataPDM_wire = 1'b0; aud_ready = 1'b0;
    a2Start = 1'b0; a2Stop = 1'b0; a2Bit = 1'b0; a2Ready = 1'b0;
    mSt = 0; mBitCnt = 0; mWarm = 0; mCur = '0; mFrame = '0; mOvf = 1'b0;
    test_reset();
    test_warmup_pack();
    test_overflow();
    test_full_collision();
    test_control();
    test_autostop();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pdm_capture_sequencer.md
Name: pdm_capture_sequencer

Overview:
- Controls the microphone PDM capture path.
- Enables the microphone and discards a configurable number of warm-up words after enable.
- Packs PDM bits into 16-bit words during capture and buffers them in a small first-word-fall-through (FWFT) FIFO.
- Hands words to the downstream PWM/audio consumer over a valid/ready handshake; sits between the mic pins and the PWM encoder in the clk_2MHz domain.

Parameters:
- FIFO_DEPTH, 8, FIFO entries; power of two, minimum 2.
- WARMUP_FRAMES, 4, completed words discarded after mic enable; 0 skips warm-up.
- NUM_FRAMES, 0, words captured before auto-stop; 0 means run until stop.

Ports:
- clk_2MHz  input  1  single clock, PDM bit rate.
- btnRST  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse, begin capture.
- stop  input  1  one-cycle pulse, end capture.
- micDataPDM_wire  input  1  PDM bit, sampled on rising edge.
- micEN  output  1  microphone enable.
- aud_data  output  16  FIFO head word.
- aud_valid  output  1  FIFO not empty.
- aud_ready  input  1  consumer accepts aud_data.
- busy  output  1  state != IDLE.
- state_o  output  2  IDLE=0, WARMUP=1, CAPTURE=2, DRAIN=3.
- overflow  output  1  sticky: a word was dropped because the FIFO was full.
- frame_cnt  output  16  words completed in CAPTURE, saturating at 0xFFFF.

Behaviour:
- Single clock domain. Reset is synchronous, active-low: btnRST==0 at a rising clk_2MHz edge resets the block. One clock, synchronous active-low reset as fixed above.
- Reset values: state IDLE, micEN=0, FIFO empty, aud_valid=0, aud_data=0, overflow=0, frame_cnt=0, bit_cnt=0, shift=0.
- Reset mid-operation discards FIFO contents and any partial word.
- Packing, active only in WARMUP and CAPTURE:
  - shift <= {shift[14:0], micDataPDM_wire}; bit_cnt increments, wraps 15->0.
  - At bit_cnt==15 the word completes as {shift[14:0], micDataPDM_wire}, with the first bit in the MSB.
  - bit_cnt and shift clear on leaving IDLE.
- FSM:
  - IDLE: micEN=0. start -> WARMUP, or -> CAPTURE if WARMUP_FRAMES==0. Clears overflow and frame_cnt on that transition. stop ignored.
  - WARMUP: micEN=1. Completed words are discarded, not pushed. After WARMUP_FRAMES completions -> CAPTURE, with no bit lost across the transition. stop -> DRAIN.
  - CAPTURE: micEN=1. Each completed word increments frame_cnt and is pushed.
    - If the FIFO is full with no pop that cycle, the word is dropped and overflow is set.
    - stop, or NUM_FRAMES!=0 with this completion making frame_cnt==NUM_FRAMES -> DRAIN. A word completing in the same cycle as stop is still pushed.
  - DRAIN: micEN=0, no packing. FIFO empty -> IDLE.
- start is ignored outside IDLE. start and stop in the same IDLE cycle: start wins.
- FIFO (FWFT):
  - aud_valid = !empty; aud_data = head entry, held stable while aud_valid && !aud_ready.
  - Pop on aud_valid && aud_ready.
  - Simultaneous push and pop when full: both occur, and the count stays full.
  - Simultaneous push and pop when empty: the pushed word appears on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: the 16th bit at edge N gives aud_valid=1 after edge N, when the FIFO was empty.

Optional Feature:
- Macro PDM_DENSITY_EN.
- Defined: the pushed word is the ones-count of the 16 completed bits, zero-extended to 16 bits (range 0..16). All-ones input gives 0x0010; alternating bits give 0x0008.
- Undefined: the pushed word is the raw packed bits.
- FSM, FIFO and counters are identical in both builds.

Test Plan:
- Reset: btnRST=0 for 2 cycles mid-CAPTURE -> state_o=0, micEN=0, aud_valid=0, aud_data=0, overflow=0, frame_cnt=0.
- Warm-up and packing: WARMUP_FRAMES=4, start pulse, pattern 0xA5C3 repeated MSB-first -> exactly 64 bits discarded, then the first aud_data=0xA5C3 (density build: 0x0008), and frame_cnt=1.
- Auto-stop: NUM_FRAMES=3, aud_ready=1 -> exactly 3 words popped, micEN falls, state DRAIN then IDLE, busy=0.
- Overflow: FIFO_DEPTH=8, aud_ready=0, 10 words completed -> 8 words held, overflow=1, frame_cnt=10. Then aud_ready=1 -> the first 8 words are output in order.
- Full push/pop collision: FIFO full, aud_ready=1 in the cycle a word completes -> the word is accepted and the FIFO stays full.
- Control corner cases:
  - stop during WARMUP -> DRAIN, then IDLE; no words pushed.
  - start during CAPTURE -> ignored.
  - start and stop in the same IDLE cycle -> WARMUP.
